integ_dump_timer: RTL and testbench

- Programmable integrate-and-dump epoch timer for the GPS correlator accumulators. Generalises the fixed-ratio accumulation prescaler.
- Runtime period with glitch-free shadow update, one-cycle slip for code-phase trimming, and sync-to-external-edge realignment.
- Emits a one-cycle dump strobe, the running sample count and an epoch counter.
- Sits between the sample clock domain and the accumulator dump/readout logic.

---
 rtl/integ_dump_timer.sv | 171 +++++++++++++++++
 tb/tb_integ_dump_timer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integ_dump_timer.sv
// Integrate-and-dump epoch timer: programmable period with shadow load, one-sample slip,
// and realignment to an external sync edge. Define INTEG_DUMP_EPOCH_EN to build the epoch counter.
module integ_dump_timer #(
    parameter int CNT_W          = 14,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int EPOCH_W        = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               en,
    input  logic [CNT_W-1:0]   period_i,
    input  logic               period_load,
    input  logic               slip,
    input  logic               sync_req,
    input  logic               sync_in,
    output logic               strobe_o,
    output logic [CNT_W-1:0]   count_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               armed_o,
    output logic               synced_o
);

    typedef enum logic [1:0] {IDLE, RUN, ARMED} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             strobe_q, strobe_d;
    logic             armed_q, armed_d;
    logic             synced_q, synced_d;
    logic             slip_busy_q, slip_busy_d;
    logic             sync_prev_q, sync_prev_d;

    logic             load_ok, running, sync_edge, slip_take, wrap;
    logic             epoch_clr, epoch_inc;
    logic [CNT_W-1:0] last_idx;

    assign last_idx = period_q - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        period_d    = period_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        strobe_d    = 1'b0;
        armed_d     = armed_q;
        synced_d    = synced_q;
        slip_busy_d = 1'b0;
        sync_prev_d = sync_in;
        epoch_clr   = 1'b0;
        epoch_inc   = 1'b0;

        load_ok   = period_load && (period_i != '0);
        running   = (state_q != IDLE);
        sync_edge = (state_q == ARMED) && sync_in && !sync_prev_q;
        // A slip already holding the count, or colliding with a realignment, is dropped.
        slip_take = running && en && slip && !slip_busy_q && !sync_edge;
        wrap      = running && (count_q >= last_idx) && !slip_take && !sync_edge;

        if (load_ok) begin
            if (state_q == IDLE) begin
                period_d  = period_i;
                pending_d = 1'b0;
            end else begin
                shadow_d  = period_i;
                pending_d = 1'b1;
            end
        end

        if (!en) begin
            state_d   = IDLE;
            count_d   = '0;
            armed_d   = 1'b0;
            synced_d  = 1'b0;
            epoch_clr = 1'b1;
        end else if (state_q == IDLE) begin
            state_d = RUN;
            count_d = '0;
        end else begin
            if (sync_edge || wrap) begin
                count_d   = '0;
                strobe_d  = 1'b1;
                // A load on the boundary edge itself governs the epoch that starts here.
                if (load_ok) begin
                    period_d = period_i;
                end else if (pending_q) begin
                    period_d = shadow_q;
                end
                pending_d = 1'b0;
            end else if (!slip_take) begin
                count_d = count_q + CNT_W'(1);
            end

            if (sync_edge) begin
                state_d   = RUN;
                armed_d   = 1'b0;
                synced_d  = 1'b1;
                epoch_clr = 1'b1;
            end else begin
                epoch_inc = wrap;
                if ((state_q == RUN) && sync_req) begin
                    state_d = ARMED;
                    armed_d = 1'b1;
                end
            end
            slip_busy_d = slip_take;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            period_q    <= CNT_W'(DEFAULT_PERIOD);
            shadow_q    <= CNT_W'(DEFAULT_PERIOD);
            pending_q   <= 1'b0;
            strobe_q    <= 1'b0;
            armed_q     <= 1'b0;
            synced_q    <= 1'b0;
            slip_busy_q <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            period_q    <= period_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            strobe_q    <= strobe_d;
            armed_q     <= armed_d;
            synced_q    <= synced_d;
            slip_busy_q <= slip_busy_d;
            sync_prev_q <= sync_prev_d;
        end
    end

`ifdef INTEG_DUMP_EPOCH_EN
    logic [EPOCH_W-1:0] epoch_q, epoch_d;

    always_comb begin
        epoch_d = epoch_q;
        if (epoch_clr) begin
            epoch_d = '0;
        end else if (epoch_inc) begin
            epoch_d = epoch_q + EPOCH_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            epoch_q <= '0;
        end else begin
            epoch_q <= epoch_d;
        end
    end

    assign epoch_o = epoch_q;
`else
    logic unused_epoch_ctl;
    assign unused_epoch_ctl = epoch_clr ^ epoch_inc;
    assign epoch_o          = '0;
`endif

    assign strobe_o = strobe_q;
    assign count_o  = count_q;
    assign armed_o  = armed_q;
    assign synced_o = synced_q;

endmodule

// File: tb/tb_integ_dump_timer.sv
// Testbench for integ_dump_timer: directed scenarios plus randomized traffic, each cycle
// compared with an epoch/period reference model kept in plain bench variables.
module tb_integ_dump_timer;

    localparam int CNT_W   = 14;
    localparam int EPOCH_W = 16;
    localparam int DEF_P   = 1000;
`ifdef INTEG_DUMP_EPOCH_EN
    localparam bit EPOCH_ON = 1'b1;
`else
    localparam bit EPOCH_ON = 1'b0;
`endif

    logic               clk_in = 1'b0;
    logic               rst, en, period_load, slip, sync_req, sync_in;
    logic [CNT_W-1:0]   period_i;
    logic               strobe_o, armed_o, synced_o;
    logic [CNT_W-1:0]   count_o;
    logic [EPOCH_W-1:0] epoch_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Reference model state
    logic               m_run, m_arm, m_synced, m_strobe, m_pending, m_slipbusy, m_prev;
    logic [CNT_W-1:0]   m_count, m_period, m_shadow;
    logic [EPOCH_W-1:0] m_epoch;

    wire [CNT_W+EPOCH_W+2:0] dut_vec = {strobe_o, count_o, epoch_o, armed_o, synced_o};
    localparam logic [CNT_W+EPOCH_W+2:0] ZERO_VEC = '0;

    integ_dump_timer #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P), .EPOCH_W(EPOCH_W)) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .period_i(period_i), .period_load(period_load),
        .slip(slip), .sync_req(sync_req), .sync_in(sync_in), .strobe_o(strobe_o),
        .count_o(count_o), .epoch_o(epoch_o), .armed_o(armed_o), .synced_o(synced_o)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5ms;
        $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
        $fatal(1);
    end

    function automatic logic [CNT_W+EPOCH_W+2:0] exp_vec();
        logic [EPOCH_W-1:0] ep;
        ep = EPOCH_ON ? m_epoch : '0;
        return {m_strobe, m_count, ep, m_arm, m_synced};
    endfunction

    function automatic logic [EPOCH_W-1:0] exp_epoch(input int n);
        return EPOCH_ON ? EPOCH_W'(n) : '0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_arm = 0; m_synced = 0; m_strobe = 0; m_pending = 0;
        m_slipbusy = 0; m_prev = 0; m_count = '0; m_epoch = '0;
        m_period = CNT_W'(DEF_P); m_shadow = CNT_W'(DEF_P);
    endtask

    // One sample of the epoch rules: boundary (realign or wrap) restarts the count,
    // otherwise count advances unless a slip is being honoured.
    task automatic model_step();
        logic ld_ok, edge_s, realign, slip_take, wrap, was_arm;
        ld_ok   = period_load && (period_i != 0);
        edge_s  = sync_in && !m_prev;
        m_prev  = sync_in;
        m_strobe = 0;
        was_arm = m_arm;
        if (!m_run) begin
            if (ld_ok) begin m_period = period_i; m_pending = 0; end
            m_run = en; m_slipbusy = 0;
        end else if (!en) begin
            if (ld_ok) begin m_shadow = period_i; m_pending = 1; end
            m_run = 0; m_count = 0; m_epoch = 0; m_arm = 0; m_synced = 0; m_slipbusy = 0;
        end else begin
            realign   = was_arm && edge_s;
            slip_take = !realign && slip && !m_slipbusy;
            wrap      = !realign && !slip_take && (int'(m_count) == int'(m_period) - 1);
            if (realign || wrap) begin
                if (ld_ok) m_period = period_i;
                else if (m_pending) m_period = m_shadow;
                m_pending = 0; m_count = 0; m_strobe = 1;
                m_epoch = realign ? '0 : m_epoch + 1'b1;
            end else begin
                if (ld_ok) begin m_shadow = period_i; m_pending = 1; end
                if (!slip_take) m_count = m_count + 1'b1;
            end
            if (realign) begin m_arm = 0; m_synced = 1; end
            else if (sync_req) m_arm = 1;
            m_slipbusy = slip_take;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        if (rst) model_reset(); else model_step();
        #1;
        cyc++;
        period_load = 0; slip = 0; sync_req = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; period_load = 0; slip = 0; sync_req = 0; sync_in = 0; period_i = '0;
        model_reset();
        repeat (3) tick();
        total_cnt++; if (dut_vec !== ZERO_VEC) $display("FAIL reset_state got=%h exp=%h", dut_vec, ZERO_VEC); else pass_cnt++;
        en = 1;
        repeat (2) tick();
        total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL reset_hold_en got=%h exp=%h", dut_vec, exp_vec()); else pass_cnt++;
    endtask

    task automatic test_default_run();
        int prev_cnt, nstrobe;
        nstrobe = 0;
        rst = 0; en = 1;
        for (int i = 0; i < 3002; i++) begin
            prev_cnt = int'(count_o);
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL default_run cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (strobe_o) begin
                nstrobe++;
                total_cnt++; if (prev_cnt != 999) $display("FAIL default_wrap_from got=%0d exp=999", prev_cnt); else pass_cnt++;
                total_cnt++; if (epoch_o !== exp_epoch(nstrobe)) $display("FAIL default_epoch got=%0d exp=%0d", epoch_o, exp_epoch(nstrobe)); else pass_cnt++;
            end
        end
        total_cnt++; if (nstrobe != 3) $display("FAIL default_strobes got=%0d exp=3", nstrobe); else pass_cnt++;
    endtask

    task automatic test_period_load();
        int gap, k;
        int exp_gaps[5] = '{600, 250, 250, 250, 250};
        for (int g = 0; g < 1100 && m_count != 400; g++) begin
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL load_pre cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
        end
        gap = 0; k = 0;
        for (int i = 0; i < 1600 && k < 5; i++) begin
            if (i == 0)   begin period_i = 250; period_load = 1; end
            if (i == 700) begin period_i = 0;   period_load = 1; end
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL load_run cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            gap++;
            if (strobe_o) begin
                total_cnt++; if (gap != exp_gaps[k]) $display("FAIL load_gap%0d got=%0d exp=%0d", k, gap, exp_gaps[k]); else pass_cnt++;
                k++; gap = 0;
            end
        end
        total_cnt++; if (k != 5) $display("FAIL load_epochs got=%0d exp=5", k); else pass_cnt++;
    endtask

    task automatic test_slip();
        int gap, phase, fired;
        int exp_gaps[4] = '{11, 11, 11, 10};
        period_i = 10; period_load = 1;
        tick();
        for (int g = 0; g < 300 && !strobe_o; g++) tick();
        total_cnt++; if (!(strobe_o && count_o == 0)) $display("FAIL slip_setup got=%0d exp=0", count_o); else pass_cnt++;
        gap = 0; phase = 0; fired = 0;
        for (int i = 0; i < 80 && phase < 4; i++) begin
            if (phase == 0 && fired == 0 && m_count == 3) begin slip = 1; fired = 1; end
            if (phase == 1 && fired == 0 && m_count == 9) begin slip = 1; fired = 1; end
            if (phase == 2 && fired < 2 && m_count == 5)  begin slip = 1; fired++; end
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL slip_run cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            gap++;
            if (strobe_o) begin
                total_cnt++; if (gap != exp_gaps[phase]) $display("FAIL slip_gap%0d got=%0d exp=%0d", phase, gap, exp_gaps[phase]); else pass_cnt++;
                phase++; gap = 0; fired = 0;
            end
        end
        total_cnt++; if (phase != 4) $display("FAIL slip_epochs got=%0d exp=4", phase); else pass_cnt++;
    endtask

    task automatic test_sync();
        int n;
        period_i = 100; period_load = 1;
        tick();
        for (int g = 0; g < 300 && !strobe_o; g++) tick();
        sync_req = 1;
        tick();
        total_cnt++; if (armed_o !== 1'b1) $display("FAIL sync_armed got=%b exp=1", armed_o); else pass_cnt++;
        for (int g = 0; g < 200 && m_count != 37; g++) begin
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL sync_wait cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
        end
        sync_in = 1;
        tick();
        total_cnt++;
        if ({strobe_o, count_o, epoch_o, synced_o, armed_o} !== {1'b1, 14'd0, 16'd0, 1'b1, 1'b0})
            $display("FAIL sync_realign got=%b/%0d/%0d/%b/%b exp=1/0/0/1/0", strobe_o, count_o, epoch_o, synced_o, armed_o);
        else pass_cnt++;
        sync_in = 0;
        n = 0;
        for (int g = 0; g < 300; g++) begin
            tick(); n++;
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL sync_after cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (strobe_o) break;
        end
        total_cnt++; if (n != 100) $display("FAIL sync_next_gap got=%0d exp=100", n); else pass_cnt++;
    endtask

    task automatic test_sync_wrap();
        int n;
        sync_req = 1;
        tick();
        for (int g = 0; g < 200 && m_count != 99; g++) tick();
        sync_in = 1;
        tick();
        total_cnt++;
        if ({strobe_o, count_o, epoch_o} !== {1'b1, 14'd0, 16'd0})
            $display("FAIL sync_wrap_coincide got=%b/%0d/%0d exp=1/0/0", strobe_o, count_o, epoch_o);
        else pass_cnt++;
        n = 0;
        for (int g = 0; g < 300; g++) begin
            tick(); n++;
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL sync_wrap_run cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (strobe_o) break;
        end
        total_cnt++; if (n != 100) $display("FAIL sync_wrap_single got=%0d exp=100", n); else pass_cnt++;
        sync_req = 1;
        for (int g = 0; g < 250; g++) begin
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL sync_held cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
        end
        total_cnt++; if ({armed_o, synced_o} !== 2'b11) $display("FAIL sync_held_armed got=%b%b exp=11", armed_o, synced_o); else pass_cnt++;
        sync_in = 0;
    endtask

    task automatic test_en_drop_rst();
        period_i = 1000; period_load = 1;
        tick();
        for (int g = 0; g < 300 && !strobe_o; g++) tick();
        for (int g = 0; g < 1100 && m_count != 500; g++) tick();
        total_cnt++; if (count_o !== 14'd500) $display("FAIL rst_setup got=%0d exp=500", count_o); else pass_cnt++;
        rst = 1;
        #1;
        total_cnt++; if (dut_vec !== ZERO_VEC) $display("FAIL rst_async got=%h exp=%h", dut_vec, ZERO_VEC); else pass_cnt++;
        model_reset();
        tick(); tick();
        rst = 0;
        for (int g = 0; g < 1100 && m_count != 500; g++) begin
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL rst_restart cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
        end
        en = 0;
        tick();
        total_cnt++; if (dut_vec !== ZERO_VEC) $display("FAIL en_drop got=%h exp=%h", dut_vec, ZERO_VEC); else pass_cnt++;
        en = 1;
        repeat (2) begin
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL en_restart cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
        end
        total_cnt++; if (count_o !== 14'd1) $display("FAIL en_restart_count got=%0d exp=1", count_o); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            en          = ($urandom_range(0, 199) != 0);
            period_load = ($urandom_range(0, 99) < 6);
            period_i    = CNT_W'($urandom_range(0, 20));
            slip        = ($urandom_range(0, 99) < 8);
            sync_req    = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 5) sync_in = ~sync_in;
            tick();
            total_cnt++; if (dut_vec !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_period_load();
        test_slip();
        test_sync();
        test_sync_wrap();
        test_en_drop_rst();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
